thermocouple_scanner: RTL and testbench

Round-robin scan controller that shares one SPI master (MAX31855-style 32-bit frame) among up to 2**CH_BITS thermocouple channels. After a power-up settling delay it selects each enabled channel in turn, requests one SPI read, waits for completion, decodes the frame and presents it as a one-cycle tagged sample. It also holds sticky per-channel fault flags. It sits between the SPI master (chip-select mux driven by `cs_sel`) and the temperature-logging logic.

---
 rtl/thermocouple_scanner_if.sv | 32 +++
 rtl/thermocouple_scanner.sv | 184 ++++++++++++++++++
 tb/tb_thermocouple_scanner.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/thermocouple_scanner_if.sv
// Signal bundle between the thermocouple scan controller, the shared SPI master
// and the temperature-logging logic. The master modport is the scanner's view.
interface thermocouple_scanner_if #(
    parameter int CH_BITS = 2
);
    localparam int N_CH = 2 ** CH_BITS;

    logic [N_CH-1:0]    ch_enable;
    logic               clear_faults;
    logic               spi_not_busy;
    logic [31:0]        spi_rx_data;
    logic               spi_ena;
    logic [CH_BITS-1:0] cs_sel;
    logic               sample_valid;
    logic [CH_BITS-1:0] sample_ch;
    logic [13:0]        tc_temp_data;
    logic [11:0]        junction_temp_data;
    logic [3:0]         fault_bits;
    logic [N_CH-1:0]    fault_sticky;

    modport master (
        input  ch_enable, clear_faults, spi_not_busy, spi_rx_data,
        output spi_ena, cs_sel, sample_valid, sample_ch,
               tc_temp_data, junction_temp_data, fault_bits, fault_sticky
    );

    modport slave (
        output ch_enable, clear_faults, spi_not_busy, spi_rx_data,
        input  spi_ena, cs_sel, sample_valid, sample_ch,
               tc_temp_data, junction_temp_data, fault_bits, fault_sticky
    );
endinterface

// File: rtl/thermocouple_scanner.sv
// Round-robin thermocouple scan controller: shares one 32-bit SPI master among
// N_CH channels, decodes each frame into a tagged sample and keeps sticky faults.
module thermocouple_scanner #(
    parameter int CLK_FREQ     = 6000,
    parameter int STARTUP_MULT = 3,
    parameter int GAP_MULT     = 1,
    parameter int CH_BITS      = 2,
    parameter int CBITS        = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    thermocouple_scanner_if.master bus
);
    localparam int N_CH = 2 ** CH_BITS;
    localparam logic [CBITS-1:0] STARTUP_LAST = CBITS'(CLK_FREQ * STARTUP_MULT - 1);
    localparam logic [CBITS-1:0] GAP_LAST     = CBITS'(CLK_FREQ * GAP_MULT - 1);

    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_PICK    = 3'd1,
        ST_REQ     = 3'd2,
        ST_BUSY    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_GAP     = 3'd5
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CBITS-1:0]   cnt_r, cnt_nxt_s;
    logic [CH_BITS-1:0] last_ch_r, cs_sel_r, sample_ch_r, pick_ch_s;
    logic               pick_found_s, capture_s, sample_valid_r;
    logic [13:0]        tc_temp_r;
    logic [11:0]        junction_temp_r;
    logic [3:0]         fault_bits_r;
    logic [N_CH-1:0]    fault_sticky_r, fault_set_s;
    logic               rx_unused_s;

    function automatic logic [CH_BITS-1:0] ch_offset(input logic [CH_BITS-1:0] base, input int off);
        ch_offset = base + CH_BITS'(off);
    endfunction

    // Round-robin search: walking offsets downward lets the nearest enabled channel after last_ch win.
    always_comb begin
        pick_found_s = 1'b0;
        pick_ch_s    = last_ch_r;
        for (int i = N_CH; i >= 1; i--) begin
            pick_found_s = pick_found_s | bus.ch_enable[ch_offset(last_ch_r, i)];
            pick_ch_s    = bus.ch_enable[ch_offset(last_ch_r, i)] ? ch_offset(last_ch_r, i) : pick_ch_s;
        end
    end

    // Next-state and delay-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_STARTUP: begin
                if (cnt_r == STARTUP_LAST) begin
                    cnt_nxt_s   = {CBITS{1'b0}};
                    state_nxt_s = ST_PICK;
                end else begin
                    cnt_nxt_s   = cnt_r + CBITS'(1);
                end
            end
            ST_PICK: begin
                if (pick_found_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_PICK;
                end
            end
            ST_REQ: begin
                if (!bus.spi_not_busy) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_BUSY: begin
                if (bus.spi_not_busy) begin
                    state_nxt_s = ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_CAPTURE: begin
                state_nxt_s = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s   = {CBITS{1'b0}};
                    state_nxt_s = ST_PICK;
                end else begin
                    cnt_nxt_s   = cnt_r + CBITS'(1);
                end
            end
            default: begin
                cnt_nxt_s   = {CBITS{1'b0}};
                state_nxt_s = ST_PICK;
            end
        endcase
    end

    // Sticky fault set mask, driven from the sample registered on BUSY exit.
    always_comb begin
        fault_set_s = {N_CH{1'b0}};
        if ((state_r == ST_CAPTURE) && fault_bits_r[3]) begin
            fault_set_s[sample_ch_r] = 1'b1;
        end else begin
            fault_set_s = {N_CH{1'b0}};
        end
    end

    assign capture_s   = (state_r == ST_BUSY) && bus.spi_not_busy;
    assign rx_unused_s = bus.spi_rx_data[17] ^ bus.spi_rx_data[3];

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_STARTUP;
            cnt_r   <= {CBITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Channel selection, held from PICK exit until the next PICK decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ch_r <= {CH_BITS{1'b1}};
            cs_sel_r  <= {CH_BITS{1'b0}};
        end else if ((state_r == ST_PICK) && pick_found_s) begin
            last_ch_r <= pick_ch_s;
            cs_sel_r  <= pick_ch_s;
        end else begin
            last_ch_r <= last_ch_r;
            cs_sel_r  <= cs_sel_r;
        end
    end

    // Frame decode: sampled on BUSY exit so the strobe is visible during CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_valid_r  <= 1'b0;
            sample_ch_r     <= {CH_BITS{1'b0}};
            tc_temp_r       <= 14'd0;
            junction_temp_r <= 12'd0;
            fault_bits_r    <= 4'd0;
        end else begin
            sample_valid_r <= capture_s;
            if (capture_s) begin
                sample_ch_r     <= cs_sel_r;
                tc_temp_r       <= bus.spi_rx_data[31:18];
                junction_temp_r <= bus.spi_rx_data[15:4];
                fault_bits_r    <= {bus.spi_rx_data[16], bus.spi_rx_data[2:0]};
            end else begin
                sample_ch_r     <= sample_ch_r;
                tc_temp_r       <= tc_temp_r;
                junction_temp_r <= junction_temp_r;
                fault_bits_r    <= fault_bits_r;
            end
        end
    end

    // Sticky faults: a coincident set beats clear_faults for its own channel only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_sticky_r <= {N_CH{1'b0}};
        end else if (bus.clear_faults) begin
            fault_sticky_r <= fault_set_s;
        end else begin
            fault_sticky_r <= fault_sticky_r | fault_set_s;
        end
    end

    assign bus.spi_ena            = (state_r == ST_REQ) && bus.spi_not_busy;
    assign bus.cs_sel             = cs_sel_r;
    assign bus.sample_valid       = sample_valid_r;
    assign bus.sample_ch          = sample_ch_r;
    assign bus.tc_temp_data       = tc_temp_r;
    assign bus.junction_temp_data = junction_temp_r;
    assign bus.fault_bits         = fault_bits_r;
    assign bus.fault_sticky       = fault_sticky_r;
endmodule

// File: tb/tb_thermocouple_scanner.sv
// Directed, table-driven bench for thermocouple_scanner (CLK_FREQ=10, STARTUP_MULT=3, GAP_MULT=1).
module tb_thermocouple_scanner;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    thermocouple_scanner_if #(.CH_BITS(2)) tif ();

    thermocouple_scanner #(
        .CLK_FREQ(10), .STARTUP_MULT(3), .GAP_MULT(1), .CH_BITS(2), .CBITS(15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] frame;
        int          busy;
        int          hold;
        bit          clr;
        logic [1:0]  ch;
        int          wt;
        logic [13:0] tc;
        logic [11:0] jn;
        logic [3:0]  fb;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs[9];
    vec_t v_park;
    vec_t v_post;
    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete read: wait for the request, play the SPI master, check the sample.
    task automatic do_read(input vec_t v);
        int n;
        n = 0;
        tif.ch_enable = v.en;
        while ((tif.spi_ena !== 1'b1) && (n < 300)) begin
            tick();
            n++;
        end
        check("ena_rise", tif.spi_ena, 1);
        if (v.wt >= 0) check("ena_latency", n, v.wt);
        check("cs_sel", tif.cs_sel, v.ch);
        for (int i = 1; i < v.hold; i++) begin
            tick();
            check("ena_hold", tif.spi_ena, 1);
        end
        tick();
        tif.spi_not_busy = 1'b0;
        #1;
        check("ena_drop", tif.spi_ena, 0);
        for (int i = 1; i < v.busy; i++) tick();
        tick();
        tif.spi_rx_data  = v.frame;
        tif.spi_not_busy = 1'b1;
        #1;
        check("valid_early", tif.sample_valid, 0);
        check("ena_in_busy", tif.spi_ena, 0);
        tick();
        check("valid", tif.sample_valid, 1);
        check("sample_ch", tif.sample_ch, v.ch);
        check("tc_temp", tif.tc_temp_data, v.tc);
        check("junction", tif.junction_temp_data, v.jn);
        check("fault_bits", tif.fault_bits, v.fb);
        check("ena_capture", tif.spi_ena, 0);
        if (v.clr) tif.clear_faults = 1'b1;
        tick();
        tif.clear_faults = 1'b0;
        check("valid_width", tif.sample_valid, 0);
        check("sticky", tif.fault_sticky, v.st);
        check("tc_hold", tif.tc_temp_data, v.tc);
        check("cs_sel_hold", tif.cs_sel, v.ch);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ena_cnt;
        int n;

        // en, frame, busy, hold, clr, ch, wait, tc, jn, fb, sticky
        vecs[0] = '{4'b1111, 32'hABCC_1234, 5, 1, 1'b0, 2'd0, 31, 14'h2AF3, 12'h123, 4'b0100, 4'b0000};
        // bit 16 of 0xABCD1234 is set, so this frame reports and latches a fault
        vecs[1] = '{4'b1111, 32'hABCD_1234, 5, 1, 1'b0, 2'd1, 11, 14'h2AF3, 12'h123, 4'b1100, 4'b0010};
        vecs[2] = '{4'b1111, 32'h0000_0000, 3, 1, 1'b0, 2'd2, 11, 14'h0000, 12'h000, 4'b0000, 4'b0010};
        vecs[3] = '{4'b1111, 32'hFFFF_FFFF, 4, 1, 1'b1, 2'd3, 11, 14'h3FFF, 12'hFFF, 4'b1111, 4'b1000};
        vecs[4] = '{4'b1111, 32'h1234_5678, 5, 1, 1'b0, 2'd0, 11, 14'h048D, 12'h567, 4'b0000, 4'b1000};
        vecs[5] = '{4'b1010, 32'h0001_0000, 2, 1, 1'b0, 2'd1, 11, 14'h0000, 12'h000, 4'b1000, 4'b1010};
        vecs[6] = '{4'b1010, 32'h0004_0007, 6, 1, 1'b0, 2'd3, 11, 14'h0001, 12'h000, 4'b0111, 4'b1010};
        vecs[7] = '{4'b1010, 32'h8000_0010, 5, 1, 1'b0, 2'd1, 11, 14'h2000, 12'h001, 4'b0000, 4'b1010};
        vecs[8] = '{4'b1010, 32'h7FFC_FFF8, 5, 7, 1'b0, 2'd3, 11, 14'h1FFF, 12'hFFF, 4'b0000, 4'b1010};
        v_park  = '{4'b0100, 32'hABCD_1234, 5, 1, 1'b1, 2'd2, 1,  14'h2AF3, 12'h123, 4'b1100, 4'b0100};
        v_post  = '{4'b1111, 32'h0123_4560, 3, 1, 1'b0, 2'd0, 31, 14'h0048, 12'h456, 4'b1000, 4'b0001};

        tif.ch_enable    = 4'b1111;
        tif.clear_faults = 1'b0;
        tif.spi_not_busy = 1'b1;
        tif.spi_rx_data  = 32'h0;
        repeat (3) tick();
        check("rst_ena", tif.spi_ena, 0);
        check("rst_cs_sel", tif.cs_sel, 0);
        check("rst_valid", tif.sample_valid, 0);
        check("rst_sticky", tif.fault_sticky, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) do_read(vecs[k]);

        // Park in PICK with nothing enabled, then wake on channel 2
        tif.ch_enable = 4'b0000;
        ena_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tif.spi_ena === 1'b1) ena_cnt++;
        end
        check("park_no_ena", ena_cnt, 0);
        do_read(v_park);

        tif.clear_faults = 1'b1;
        tick();
        tif.clear_faults = 1'b0;
        check("clear_later", tif.fault_sticky, 0);

        // Reset asserted mid-transfer clears everything immediately
        tif.ch_enable = 4'b1111;
        n = 0;
        while ((tif.spi_ena !== 1'b1) && (n < 300)) begin
            tick();
            n++;
        end
        check("rb_ena_rise", tif.spi_ena, 1);
        check("rb_cs_sel", tif.cs_sel, 3);
        tick();
        tif.spi_not_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rb_ena", tif.spi_ena, 0);
        check("rb_cs", tif.cs_sel, 0);
        check("rb_valid", tif.sample_valid, 0);
        check("rb_sample_ch", tif.sample_ch, 0);
        check("rb_tc", tif.tc_temp_data, 0);
        check("rb_jn", tif.junction_temp_data, 0);
        check("rb_fb", tif.fault_bits, 0);
        check("rb_sticky", tif.fault_sticky, 0);
        repeat (3) tick();
        tif.spi_not_busy = 1'b1;
        tif.spi_rx_data  = 32'h0;
        rst_n = 1'b1;
        do_read(v_post);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
